// File: rtl/cpc_ram_pkg.sv
// cpc_ram_pkg: shared bus-cycle states and RAM configuration field layout.
package cpc_ram_pkg;
  localparam int BANK_W = 3;
  localparam int BLOCK_W = 3;
  localparam int CFG_W = BANK_W + BLOCK_W;
  localparam logic [1:0] CFG_PORT_TAG = 2'b11;
  localparam logic [BLOCK_W-1:0] MODE3_BLOCK = 3'b011;
  typedef enum logic [7:0] {
    IDLE = 8'b0000_0001,
    MEM  = 8'b0000_0010,
    MWR  = 8'b0000_0100,
    MRD  = 8'b0000_1000,
    IO   = 8'b0001_0000,
    IOWR = 8'b0010_0000,
    IORD = 8'b0100_0000,
    RFSH = 8'b1000_0000
  } cyc_state_e;
endpackage

// File: rtl/cpc_cfg_reg.sv
// cpc_cfg_reg: RAM configuration capture register, mode-3 predecode and one-capture-per-IO-write guard.
module cpc_cfg_reg
  import cpc_ram_pkg::*;
#(
  parameter logic [CFG_W-1:0] CFG_RESET = '0
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             in_iowr,
  input  logic             sel,
  input  logic [CFG_W-1:0] din,
  output logic             cfg_stb,
  output logic [CFG_W-1:0] ram_cfg,
  output logic             mode3
);
  logic seen;
  logic cap;
  // seen marks that IOWR has already been occupied for a clock, so wait states never recapture
  assign cap = in_iowr && !seen && sel;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      seen    <= 1'b0;
      cfg_stb <= 1'b0;
      ram_cfg <= CFG_RESET;
      mode3   <= CFG_RESET[BLOCK_W-1:0] == MODE3_BLOCK;
    end else begin
      seen    <= in_iowr;
      cfg_stb <= cap;
      if (cap) begin
        ram_cfg <= din;
        mode3   <= din[BLOCK_W-1:0] == MODE3_BLOCK;
      end
    end
endmodule

// File: rtl/cpc_bus_cycle_decoder.sv
// cpc_bus_cycle_decoder: Z80 bus-cycle classifier feeding the 512K RAM mapper, with 0x7Fxx RAM config capture.
// Define MWR_EXTEND_EN to stretch mwr_cyc by one clock past the end of a memory write.
module cpc_bus_cycle_decoder
  import cpc_ram_pkg::*;
#(
  parameter logic [5:0] CFG_RESET = 6'b000000
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       mreq_b,
  input  logic       iorq_b,
  input  logic       rd_b,
  input  logic       wr_b,
  input  logic       m1_b,
  input  logic       rfsh_b,
  input  logic       adr15,
  input  logic [7:0] data,
  output logic       mwr_cyc,
  output logic       mrd_cyc,
  output logic       iowr_cyc,
  output logic       cfg_stb,
  output logic [5:0] ram_cfg,
  output logic       mode3
);
  cyc_state_e state, state_nx;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) state <= IDLE;
    else state <= state_nx;
  // memory strobes win over IORQ; interrupt acknowledge (IORQ with M1) is ignored
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:            state_nx = !mreq_b ? (!rfsh_b ? RFSH : !rd_b ? MRD : MEM)
                                          : (!iorq_b && m1_b) ? IO : IDLE;
      MEM:             state_nx = !wr_b ? MWR : !rd_b ? MRD : mreq_b ? IDLE : MEM;
      MWR, MRD, RFSH:  state_nx = mreq_b ? IDLE : state;
      IO:              state_nx = !wr_b ? IOWR : !rd_b ? IORD : iorq_b ? IDLE : IO;
      IOWR, IORD:      state_nx = iorq_b ? IDLE : state;
      default:         state_nx = IDLE;
    endcase
  end
  assign mrd_cyc  = state == MRD;
  assign iowr_cyc = state == IOWR;
`ifdef MWR_EXTEND_EN
  logic mwr_hold;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) mwr_hold <= 1'b0;
    else mwr_hold <= state == MWR;
  assign mwr_cyc = state == MWR || mwr_hold;
`else
  assign mwr_cyc = state == MWR;
`endif
  cpc_cfg_reg #(.CFG_RESET(CFG_RESET)) u_cfg (
    .clk     (clk),
    .reset_b (reset_b),
    .in_iowr (state == IOWR),
    .sel     (!adr15 && data[7:6] == CFG_PORT_TAG),
    .din     (data[5:0]),
    .cfg_stb (cfg_stb),
    .ram_cfg (ram_cfg),
    .mode3   (mode3)
  );
endmodule

// File: tb/tb_cpc_bus_cycle_decoder.sv
// tb_cpc_bus_cycle_decoder: randomized bus transactions with a pulse-length/config scoreboard.
module tb_cpc_bus_cycle_decoder;
`ifdef MWR_EXTEND_EN
  localparam int EXT = 1;
`else
  localparam int EXT = 0;
`endif
  localparam logic [5:0] IDL = 6'b111111;
  logic clk = 0, reset_b = 1;
  logic mreq_b = 1, iorq_b = 1, rd_b = 1, wr_b = 1, m1_b = 1, rfsh_b = 1, adr15 = 1;
  logic [7:0] data = 0;
  logic mwr_cyc, mrd_cyc, iowr_cyc, cfg_stb, mode3;
  logic [5:0] ram_cfg;
  int checks = 0, passed = 0;
  int q_mwr[$], q_mrd[$], q_iowr[$];
  logic [5:0] q_cfg[$];
  logic [5:0] cfg_model = 6'h00;
  logic mon_en = 0;
  int l_mwr = 0, l_mrd = 0, l_iow = 0, l_stb = 0;

  always #5 clk = ~clk;

  cpc_bus_cycle_decoder #(.CFG_RESET(6'b000000)) dut (
    .clk(clk), .reset_b(reset_b), .mreq_b(mreq_b), .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b),
    .m1_b(m1_b), .rfsh_b(rfsh_b), .adr15(adr15), .data(data), .mwr_cyc(mwr_cyc),
    .mrd_cyc(mrd_cyc), .iowr_cyc(iowr_cyc), .cfg_stb(cfg_stb), .ram_cfg(ram_cfg), .mode3(mode3)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // strobes {mreq,iorq,rd,wr,m1,rfsh}, held for n sampling edges; entered and left at posedge+2
  task automatic drv(input logic [5:0] s, input int n);
    {mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b} = s;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic gap();
    drv(IDL, $urandom_range(1, 3));
    chk("ram_cfg_hold", ram_cfg, cfg_model);
  endtask

  task automatic mem_write(input int na, input int nw, input bit both);
    q_mwr.push_back(nw + EXT);
    drv(both ? 6'b001111 : 6'b011111, na);
    drv(both ? 6'b001011 : 6'b011011, nw);
    gap();
  endtask

  task automatic fetch(input int nr, input int nf);
    q_mrd.push_back(nr);
    drv(6'b010101, nr);
    drv(IDL, 1);
    drv(6'b011110, nf);
    gap();
  endtask

  task automatic mem_read(input int na, input int nr);
    q_mrd.push_back(nr);
    drv(6'b011111, na);
    drv(6'b010111, nr);
    gap();
  endtask

  task automatic io_write(input int na, input int nw, input logic a15, input logic [7:0] d);
    adr15 = a15;
    data = d;
    q_iowr.push_back(nw);
    if (!a15 && d / 64 == 3) begin
      cfg_model = d[5:0];
      q_cfg.push_back(d[5:0]);
    end
    drv(6'b101111, na);
    drv(6'b101011, nw);
    gap();
  endtask

  task automatic io_read(input int na, input int nr);
    drv(6'b101111, na);
    drv(6'b100111, nr);
    gap();
  endtask

  always @(negedge clk) if (mon_en) begin
    logic [5:0] e;
    if (mwr_cyc) l_mwr++;
    else if (l_mwr > 0) begin
      if (q_mwr.size() == 0) chk("mwr_unexpected", l_mwr, 0);
      else chk("mwr_len", l_mwr, q_mwr.pop_front());
      l_mwr = 0;
    end
    if (mrd_cyc) l_mrd++;
    else if (l_mrd > 0) begin
      if (q_mrd.size() == 0) chk("mrd_unexpected", l_mrd, 0);
      else chk("mrd_len", l_mrd, q_mrd.pop_front());
      l_mrd = 0;
    end
    if (iowr_cyc) l_iow++;
    else if (l_iow > 0) begin
      if (q_iowr.size() == 0) chk("iowr_unexpected", l_iow, 0);
      else chk("iowr_len", l_iow, q_iowr.pop_front());
      l_iow = 0;
    end
    if (cfg_stb) begin
      if (l_stb == 0) begin
        if (q_cfg.size() == 0) chk("stb_unexpected", 1, 0);
        else begin
          e = q_cfg.pop_front();
          chk("ram_cfg", ram_cfg, e);
          chk("mode3", mode3, (e % 8 == 3) ? 1 : 0);
        end
      end
      l_stb++;
    end else if (l_stb > 0) begin
      chk("stb_len", l_stb, 1);
      l_stb = 0;
    end
  end

  initial begin
    logic [7:0] d;
    #1 reset_b = 0;
    #10;
    chk("rst_ram_cfg", ram_cfg, 0);
    chk("rst_mode3", mode3, 0);
    chk("rst_outs", {mwr_cyc, mrd_cyc, iowr_cyc, cfg_stb}, 0);
    @(posedge clk);
    #2 reset_b = 1;
    mon_en = 1;
    drv(IDL, 3);
    chk("idle_outs", {mwr_cyc, mrd_cyc, iowr_cyc, cfg_stb}, 0);
    io_write(1, 2, 0, 8'hC3);
    chk("c3_mode3", mode3, 1);
    io_write(1, 2, 0, 8'h8C);
    io_write(1, 3, 1, 8'hFF);
    mem_write(1, 4, 0);
    fetch(2, 1);
    mem_write(1, 2, 1);
    drv(6'b101101, 2);
    gap();
    repeat (60) begin
      case ($urandom_range(0, 6))
        0: mem_write($urandom_range(1, 2), $urandom_range(1, 4), 0);
        1: fetch($urandom_range(1, 3), $urandom_range(1, 2));
        2: mem_read($urandom_range(1, 2), $urandom_range(1, 4));
        3, 4: begin
          d = 8'($urandom);
          if ($urandom_range(0, 1) == 1) d[7:6] = 2'b11;
          io_write($urandom_range(1, 2), $urandom_range(1, 4), 1'($urandom_range(0, 1)), d);
        end
        5: io_read($urandom_range(1, 2), $urandom_range(1, 3));
        default: begin
          drv(6'b101101, $urandom_range(1, 2));
          gap();
        end
      endcase
    end
    io_write(1, 2, 0, 8'hC5);
    chk("pre_rst_cfg", ram_cfg, 6'h05);
    adr15 = 0;
    data = 8'hCA;
    q_iowr.push_back(1);
    drv(6'b101111, 1);
    drv(6'b101011, 1);
    #5 reset_b = 0;
    {mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b} = IDL;
    cfg_model = 6'h00;
    #2;
    chk("midrst_iowr", iowr_cyc, 0);
    chk("midrst_cfg", ram_cfg, 0);
    chk("midrst_stb", cfg_stb, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_b = 1;
    drv(IDL, 2);
    chk("postrst_cfg", ram_cfg, 0);
    chk("postrst_mode3", mode3, 0);
    chk("postrst_outs", {mwr_cyc, mrd_cyc, iowr_cyc, cfg_stb}, 0);
    mem_write(1, 3, 0);
    drv(IDL, 4);
    chk("q_mwr_left", q_mwr.size(), 0);
    chk("q_mrd_left", q_mrd.size(), 0);
    chk("q_iowr_left", q_iowr.size(), 0);
    chk("q_cfg_left", q_cfg.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
